// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side frame buffer behind the UART receiver.
// Captures one {parity-error tag, data} entry on each rising edge of the
// receiver's done flag. Frames are held in a circular FIFO and returned to the
// host through a registered one-cycle read strobe.
//
// Ports:
//   rx_clk       clock (same domain as the receiver's baud tick)
//   rst          asynchronous, active-high reset
//   rx_done_in   receiver done flag (low while a frame is in progress)
//   rx_data_in   receiver parallel data, valid when rx_done_in rises
//   rx_error_in  receiver parity-error flag, may pulse only while done is low
//   rd_en        host read request
//   clr_overrun  clears the sticky overrun flag
//   rd_data      read data (holds its value between reads)
//   rd_error     parity-error tag of the entry that was read
//   rd_valid     one-cycle strobe qualifying rd_data/rd_error
//   empty        FIFO holds no entries
//   full         FIFO holds DEPTH entries
//   almost_full  count >= AF_LEVEL
//   count        occupancy, 0..DEPTH
//   overrun      sticky flag, set when a frame is dropped
module uart_rx_fifo #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned AF_LEVEL = 12
) (
   input  logic              rx_clk,
   input  logic              rst,
   input  logic              rx_done_in,
   input  logic [DATA_W-1:0] rx_data_in,
   input  logic              rx_error_in,
   input  logic              rd_en,
   input  logic              clr_overrun,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_error,
   output logic              rd_valid,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
   output logic [ADDR_W:0]   count,
   output logic              overrun
);

   localparam int unsigned CNT_W   = ADDR_W + 1;
   localparam int unsigned ENTRY_W = DATA_W + 1;

   logic [ENTRY_W-1:0] mem [DEPTH];

   logic               done_q;
   logic               err_cap_q,   err_cap_d;
   logic [ADDR_W-1:0]  wptr_q,      wptr_d;
   logic [ADDR_W-1:0]  rptr_q,      rptr_d;
   logic [CNT_W-1:0]   count_q,     count_d;
   logic               empty_q,     empty_d;
   logic               full_q,      full_d;
   logic               afull_q,     afull_d;
   logic [DATA_W-1:0]  rd_data_q,   rd_data_d;
   logic               rd_error_q,  rd_error_d;
   logic               rd_valid_q,  rd_valid_d;
   logic               overrun_q,   overrun_d;

   logic               wr_evt;
   logic               rd_acc;
   logic               wr_acc;
   logic               wr_drop;
   logic               tag;

   // Next-state logic for pointers, occupancy, flags and the read port
   always_comb begin
      err_cap_d  = err_cap_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_error_d = rd_error_q;
      rd_valid_d = 1'b0;
      overrun_d  = overrun_q;

      wr_evt  = rx_done_in & ~done_q;
      tag     = err_cap_q | rx_error_in;
      rd_acc  = rd_en & ~empty_q;
      // A read in the same cycle frees the slot, so a full FIFO still accepts
      wr_acc  = wr_evt & (~full_q | rd_acc);
      wr_drop = wr_evt & ~wr_acc;

      // Receiver drops its error flag when done rises, so hold it across the frame
      if (wr_evt) begin
         err_cap_d = 1'b0;
      end else if (rx_error_in && !rx_done_in) begin
         err_cap_d = 1'b1;
      end

      if (rd_acc) begin
         rd_data_d  = mem[rptr_q][DATA_W-1:0];
         rd_error_d = mem[rptr_q][DATA_W];
         rd_valid_d = 1'b1;
         rptr_d     = rptr_q + ADDR_W'(1);
      end

      if (wr_acc) begin
         wptr_d = wptr_q + ADDR_W'(1);
      end

      count_d = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
      empty_d = (count_d == CNT_W'(0));
      full_d  = (count_d == CNT_W'(DEPTH));
      afull_d = (count_d >= CNT_W'(AF_LEVEL));

      // A drop in the same cycle as a clear leaves the flag set
      if (wr_drop) begin
         overrun_d = 1'b1;
      end else if (clr_overrun) begin
         overrun_d = 1'b0;
      end
   end

   // Control and status registers
   always_ff @(posedge rx_clk or posedge rst) begin
      if (rst) begin
         done_q     <= 1'b1;
         err_cap_q  <= 1'b0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         afull_q    <= 1'b0;
         rd_data_q  <= '0;
         rd_error_q <= 1'b0;
         rd_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         done_q     <= rx_done_in;
         err_cap_q  <= err_cap_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         afull_q    <= afull_d;
         rd_data_q  <= rd_data_d;
         rd_error_q <= rd_error_d;
         rd_valid_q <= rd_valid_d;
         overrun_q  <= overrun_d;
      end
   end

   // Storage array; contents are qualified by the pointers, so no reset
   always_ff @(posedge rx_clk) begin
      if (wr_acc) begin
         mem[wptr_q] <= {tag, rx_data_in};
      end
   end

   assign rd_data     = rd_data_q;
   assign rd_error    = rd_error_q;
   assign rd_valid    = rd_valid_q;
   assign empty       = empty_q;
   assign full        = full_q;
   assign almost_full = afull_q;
   assign count       = count_q;
   assign overrun     = overrun_q;

endmodule
